// File: rtl/mem_responder_pkg.sv
// Shared types for the cache controller's memory interface and the memory-side responder.
package mem_responder_pkg;

  typedef logic [127:0] cache_data_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           valid;
  } mem_data_type;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    COOL = 2'd3
  } mem_rsp_state_e;

  localparam int MEM_LINE_BYTES  = 16;
  localparam int MEM_OFFSET_BITS = $clog2(MEM_LINE_BYTES);

  // Fibonacci step of the 8-bit maximal-length LFSR, taps 8,6,5,4.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between a requester (master) and the memory responder (slave).
interface mem_responder_if;
  import mem_responder_pkg::*;

  mem_req_type  mem_req;
  mem_data_type mem_data;
  logic         busy;

  modport master (output mem_req, input mem_data, input busy);
  modport slave  (input mem_req, output mem_data, output busy);

endinterface

// File: rtl/mem_rsp_lfsr.sv
// 8-bit LFSR (seed 8'hA5) that steps once per advance pulse; exists only when
// MEM_RSP_RANDOM_LAT_EN is defined.
`ifdef MEM_RSP_RANDOM_LAT_EN
module mem_rsp_lfsr
  import mem_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       adv_i,
  output logic [7:0] lfsr_o
);

  localparam logic [7:0] SEED = 8'hA5;

  logic [7:0] lfsr_q;

  // Shift register state, advanced only on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (adv_i) begin
      lfsr_q <= lfsr8_next(lfsr_q);
    end else begin
      lfsr_q <= lfsr_q;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule
`endif

// File: rtl/mem_responder.sv
// Fixed-latency memory responder backed by a 2^DEPTH_LOG2 x 128-bit line store.
// Optional MEM_RSP_RANDOM_LAT_EN adds 0..3 extra cycles of LFSR-driven latency per request.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_responder_if.slave mem_if_io
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  cache_data_type store [DEPTH];

  mem_rsp_state_e state_q;
  idx_t           idx_q;
  cache_data_type wdata_q;
  logic           rw_q;
  logic [8:0]     cnt_q;
  cache_data_type data_q;
  logic           valid_q;
  logic           busy_q;

  idx_t           req_idx_s;
  idx_t           rd_idx_s;
  cache_data_type rd_line_s;
  logic [8:0]     eff_lat_s;
  logic           accept_s;
  logic           unused_addr_s;

  assign req_idx_s     = mem_if_io.mem_req.addr[MEM_OFFSET_BITS +: DEPTH_LOG2];
  assign unused_addr_s = ^{mem_if_io.mem_req.addr[MEM_OFFSET_BITS-1:0],
                           mem_if_io.mem_req.addr[31:MEM_OFFSET_BITS+DEPTH_LOG2]};
  assign accept_s      = (state_q == IDLE) && mem_if_io.mem_req.valid;

`ifdef MEM_RSP_RANDOM_LAT_EN
  logic [7:0] lfsr_s;
  logic       unused_lfsr_s;

  mem_rsp_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .adv_i  (accept_s),
    .lfsr_o (lfsr_s)
  );

  // Latency uses the LFSR value before this acceptance advances it.
  assign eff_lat_s     = 9'(LATENCY) + {7'd0, lfsr_s[1:0]};
  assign unused_lfsr_s = ^lfsr_s[7:2];
`else
  assign eff_lat_s = 9'(LATENCY);
`endif

  // Read port addresses the incoming request in IDLE (latency-1 path), else the held index.
  always_comb begin
    rd_idx_s = idx_q;
    if (state_q == IDLE) begin
      rd_idx_s = req_idx_s;
    end else begin
      rd_idx_s = idx_q;
    end
  end

  assign rd_line_s = store[rd_idx_s];

  // Line store: a write commits only on the edge that ends RESP.
  always_ff @(posedge clk) begin
    if ((state_q == RESP) && rw_q) begin
      store[idx_q] <= wdata_q;
    end
  end

  // Request FSM; response valid is high in the cycle ending LATENCY edges after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      cnt_q   <= 9'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            idx_q   <= req_idx_s;
            wdata_q <= mem_if_io.mem_req.data;
            rw_q    <= mem_if_io.mem_req.rw;
            busy_q  <= 1'b1;
            cnt_q   <= eff_lat_s - 9'd1;
            if (eff_lat_s == 9'd1) begin
              state_q <= RESP;
              valid_q <= 1'b1;
              data_q  <= mem_if_io.mem_req.rw ? mem_if_io.mem_req.data : rd_line_s;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            state_q <= RESP;
            valid_q <= 1'b1;
            data_q  <= rw_q ? wdata_q : rd_line_s;
          end
        end
        RESP: begin
          valid_q <= 1'b0;
          state_q <= COOL;
        end
        COOL: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= 9'd0;
        end
      endcase
    end
  end

  assign mem_if_io.mem_data = '{data: data_q, valid: valid_q};
  assign mem_if_io.busy     = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed requests push expected responses,
// a negedge monitor checks valid/data/busy every cycle.
module tb_mem_responder;
  import mem_responder_pkg::*;

`ifdef MEM_RSP_RANDOM_LAT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 4;
`endif
  localparam int DL = 10;
  localparam logic [127:0] LINE_A = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  typedef struct {
    int           cyc;
    logic [127:0] data;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  int         cyc   = 0;
  int         n_vec = 0;
  int         n_err = 0;
  exp_t       sb[$];
  bit         busy_exp[int];
  logic [7:0] lfsr_m = 8'hA5;

  mem_responder_if bus ();

  mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(DL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_if_io (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  // Reference latency for the next acceptance (steps the reference LFSR when enabled).
  function automatic int next_lat();
    int l;
    l = LAT;
`ifdef MEM_RSP_RANDOM_LAT_EN
    l = LAT + int'(lfsr_m[1:0]);
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`endif
    return l;
  endfunction

  // Called #1 after the accepting edge: records expected pulse cycle and busy window.
  task automatic book(input logic [127:0] exp, output int acc, output int lat);
    acc = cyc;
    lat = next_lat();
    sb.push_back('{cyc: acc + lat - 1, data: exp});
    for (int i = 0; i <= lat; i++) busy_exp[acc + i] = 1'b1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [127:0] d, input logic w);
    @(negedge clk);
    bus.mem_req = '{addr: a, data: d, rw: w, valid: 1'b1};
  endtask

  task automatic xfer(input logic [31:0] a, input logic [127:0] d, input logic w,
                      input logic [127:0] exp);
    int acc;
    int lat;
    drive(a, d, w);
    @(posedge clk);
    #1;
    book(exp, acc, lat);
    bus.mem_req = '{addr: ~a, data: ~d, rw: ~w, valid: 1'b0};
    repeat (lat + 1) @(posedge clk);
  endtask

  // Monitor: every cycle out of reset, valid must match the scoreboard head exactly.
  always @(negedge clk) begin
    bit ev;
    if (rst_n) begin
      ev = (sb.size() > 0) && (sb[0].cyc == cyc);
      check("valid", {127'd0, bus.mem_data.valid}, {127'd0, ev});
      check("busy", {127'd0, bus.busy}, {127'd0, busy_exp.exists(cyc)});
      if (ev) begin
        if (bus.mem_data.valid) check("data", bus.mem_data.data, sb[0].data);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int lat;
    bus.mem_req = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      #1;
      check("rst_valid", {127'd0, bus.mem_data.valid}, 128'd0);
      check("rst_data", bus.mem_data.data, 128'd0);
      check("rst_busy", {127'd0, bus.busy}, 128'd0);
    end

    xfer(32'h0000_0120, LINE_A, 1'b1, LINE_A);
    xfer(32'h0000_012C, 128'd0, 1'b0, LINE_A);
    xfer(32'h0000_4120, 128'h1, 1'b1, 128'h1);
    xfer(32'h0000_0120, 128'd0, 1'b0, 128'h1);
    xfer(32'h0000_0050, 128'hAA, 1'b1, 128'hAA);

    // Held valid: second read must be accepted exactly lat+2 edges after the first.
    drive(32'h0000_0120, 128'd0, 1'b0);
    @(posedge clk);
    #1;
    book(128'h1, acc, lat);
    bus.mem_req.addr = 32'h0000_0050;
    repeat (lat + 2) @(posedge clk);
    #1;
    book(128'hAA, acc, lat);
    bus.mem_req.valid = 1'b0;
    repeat (lat + 1) @(posedge clk);

    // Reset during WAIT of a write: no pulse afterwards, line keeps old content.
    drive(32'h0000_0050, 128'hBB, 1'b1);
    @(posedge clk);
    #1;
    lat = next_lat();
    busy_exp[cyc] = 1'b1;
    bus.mem_req.valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    lfsr_m = 8'hA5;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (LAT + 8) @(posedge clk);
    xfer(32'h0000_0050, 128'd0, 1'b0, 128'hAA);

    for (int i = 0; i < 16; i++) begin
      if (i[0]) xfer(32'h0000_0120, 128'd0, 1'b0, 128'h1);
      else      xfer(32'h0000_0050, 128'd0, 1'b0, 128'hAA);
    end

    repeat (4) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
